rr_arbiter2x1: RTL



---
 rtl/rr_arbiter2x1.sv | 77 +++++++
 1 files changed

// File: rtl/rr_arbiter2x1.sv
// Two-input round-robin arbiter with a registered output stage driving a 2:1 mux select.
// Define RR_ARBITER2X1_FIXED_PRIO_EN for fixed priority (in1 always wins conflicts).
module rr_arbiter2x1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    input  logic             in2_valid,
    input  logic [WIDTH-1:0] in2_data,
    output logic             in2_ready,
    output logic             select,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state;
    logic   load;
    logic   grant1;
    logic   grant2;

`ifndef RR_ARBITER2X1_FIXED_PRIO_EN
    // Most recent grant in select encoding (1 = in2), so in1 wins the first conflict.
    logic last;
`endif

    assign out_valid = (state == FULL);
    assign in1_ready = grant1;
    assign in2_ready = grant2;

    always_comb begin
        load   = !rst && ((state == EMPTY) || out_ready);
        grant1 = 1'b0;
        grant2 = 1'b0;
        if (load) begin
            if (in1_valid && in2_valid) begin
`ifdef RR_ARBITER2X1_FIXED_PRIO_EN
                grant1 = 1'b1;
`else
                grant1 = last;
                grant2 = !last;
`endif
            end else begin
                grant1 = in1_valid;
                grant2 = in2_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            select   <= 1'b0;
`ifndef RR_ARBITER2X1_FIXED_PRIO_EN
            last     <= 1'b1;
`endif
        end else if (load) begin
            if (grant1 || grant2) begin
                state    <= FULL;
                out_data <= grant2 ? in2_data : in1_data;
                select   <= grant2;
`ifndef RR_ARBITER2X1_FIXED_PRIO_EN
                last     <= grant2;
`endif
            end else begin
                state <= EMPTY;
            end
        end
    end

endmodule
